// File: rtl/uart_imem_loader_pkg.sv
// uart_imem_loader_pkg: shared states, constants and bit-timing helper for the UART imem loader.
package uart_imem_loader_pkg;

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int clks_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchronizer, start-glitch rejection and stop-bit check.
module uart_rx_byte
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    rx_state_t     state;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tick;

    assign tick = cnt == CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= RX_IDLE;
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            framing_err <= 1'b0;
        end else begin
            {rx_prev, rx_sync, rx_meta} <= {rx_sync, rx_meta, rx};
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
            cnt         <= (state == RX_IDLE || tick) ? '0 : cnt + 1'b1;
            case (state)
                RX_IDLE: if (rx_prev && !rx_sync) state <= RX_START;
                // half a bit into the start bit: a high line here was only a glitch
                RX_START: if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= rx_sync ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (tick) begin
                    shift   <= {rx_sync, shift[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= RX_STOP;
                end
                RX_STOP: if (tick) begin
                    state       <= RX_IDLE;
                    byte_valid  <= rx_sync;
                    framing_err <= !rx_sync;
                    byte_data   <= shift;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: loads framed UART images into imem, holding the core in reset while loading.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 byte-sum after the data words.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int CLOCK_HZ       = 27000000,
    parameter int BAUD           = 115200,
    parameter int ADDR_BITS      = 9,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 uart_rx,
    output logic [ADDR_BITS-1:0] imem_write_address,
    output logic [31:0]          imem_write_data,
    output logic                 imem_write_enable,
    output logic                 core_hold,
    output logic                 load_done,
    output logic                 load_error
);
    localparam int          CPB      = clks_per_bit(CLOCK_HZ, BAUD);
    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 2);
    localparam int          WB       = ADDR_BITS + 1;
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_BITS);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t      LAST     = CHECK;
`else
    localparam state_t      LAST     = DONE;
`endif

    state_t        state;
    logic          byte_valid, framing_err, timed_out;
    logic [7:0]    byte_data, len_lo;
    logic [16:0]   len_n;
    logic [WB-1:0] word_cnt, len_words;
    logic [1:0]    byte_idx;
    logic [23:0]   word_lo;
    logic [TW-1:0] gap;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
        .clock       (clock),
        .resetn      (resetn),
        .rx          (uart_rx),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .framing_err (framing_err)
    );

    assign timed_out = gap > TW'(TIMEOUT_CYCLES);
    assign len_n     = {1'b0, byte_data, len_lo};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state              <= IDLE;
            imem_write_address <= '0;
            imem_write_data    <= '0;
            imem_write_enable  <= 1'b0;
            core_hold          <= 1'b0;
            load_done          <= 1'b0;
            load_error         <= 1'b0;
            len_lo             <= '0;
            word_cnt           <= '0;
            len_words          <= '0;
            byte_idx           <= '0;
            word_lo            <= '0;
            gap                <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum               <= '0;
`endif
        end else begin
            imem_write_enable <= 1'b0;
            load_done         <= 1'b0;
            // saturating gap counter so a long stall cannot wrap back under the limit
            gap <= (state == IDLE || byte_valid) ? '0 : timed_out ? gap : gap + 1'b1;
            case (state)
                IDLE: if (byte_valid && byte_data == SYNC_BYTE) begin
                    load_error <= 1'b0;
                    core_hold  <= 1'b1;
                    state      <= LEN_LO;
`ifdef LOADER_CHECKSUM_EN
                    csum       <= '0;
`endif
                end
                DONE: begin
                    load_done <= 1'b1;
                    core_hold <= 1'b0;
                    state     <= IDLE;
                end
                ERROR: begin
                    load_error <= 1'b1;
                    state      <= IDLE;
                end
                default: if (framing_err || timed_out) state <= ERROR;
                else if (byte_valid) case (state)
                    LEN_LO: begin
                        len_lo <= byte_data;
                        state  <= LEN_HI;
                    end
                    LEN_HI: begin
                        len_words <= WB'(len_n);
                        word_cnt  <= '0;
                        byte_idx  <= '0;
                        state     <= len_n == 17'd0 ? DONE : len_n > CAPACITY ? ERROR : DATA;
                    end
                    DATA: begin
                        byte_idx <= byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum + byte_data;
`endif
                        if (byte_idx == 2'd3) begin
                            imem_write_enable  <= 1'b1;
                            imem_write_address <= word_cnt[ADDR_BITS-1:0];
                            imem_write_data    <= {byte_data, word_lo};
                            word_cnt           <= word_cnt + 1'b1;
                            if (word_cnt + 1'b1 == len_words) state <= LAST;
                        end else begin
                            word_lo[{byte_idx, 3'b000} +: 8] <= byte_data;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHECK: state <= byte_data == csum ? DONE : ERROR;
`endif
                    default: state <= IDLE;
                endcase
            endcase
        end
    end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Serial program loader upstream of the on-chip instruction RAM.
- Receives a framed binary image on uart_rx, emits one word-write per received 32-bit word on a write port that muxes into the imem write path, and holds the core in reset while loading.
- Lets the team replace the bootrom contents at runtime without re-synthesis.

Parameters:
- CLOCK_HZ, 27000000, input clock frequency in Hz
- BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLOCK_HZ/BAUD (integer division, must be >= 4)
- ADDR_BITS, 9, imem word-address width; capacity = 2**ADDR_BITS words
- TIMEOUT_CYCLES, 2700000, max idle cycles between bytes inside a frame

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- uart_rx  in  1  asynchronous serial input, idle high
- imem_write_address  out  ADDR_BITS  word address (not byte address)
- imem_write_data  out  32  little-endian assembled word
- imem_write_enable  out  1  one-cycle write strobe
- core_hold  out  1  high = core must be held in reset
- load_done  out  1  one-cycle pulse on successful load
- load_error  out  1  sticky error flag

Behaviour:
- Interface: one clock, `clock`; reset `resetn` is synchronous and active-low. All state updates on posedge clock only.
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- RX front end:
  - 2-flop synchronizer on uart_rx.
  - Start is a falling edge of the synchronized line. Wait CLKS_PER_BIT/2, then re-check low; if high, treat as a glitch and return to idle.
  - Sample 8 data bits LSB-first at bit centres, then the stop bit.
  - Stop bit = 1: byte_valid pulses one cycle with the byte.
  - Stop bit = 0: framing_err pulses one cycle and no byte is produced.
- Frame format: SYNC (0xA5), LEN_LO, LEN_HI (16-bit word count N), then N×4 data bytes, least-significant byte first.
- FSM:
  - IDLE: non-0xA5 bytes and framing errors are ignored. On 0xA5: clear load_error, set core_hold=1, go to LEN_LO.
  - LEN_LO → LEN_HI on a byte. After LEN_HI:
    - N=0 → DONE.
    - N > 2**ADDR_BITS → ERROR.
    - Otherwise → DATA with word address 0 and byte index 0.
  - DATA: shift each byte into position byte_index×8. On byte_index=3:
    - Drive imem_write_enable=1 for exactly one cycle (the cycle after the byte_valid).
    - imem_write_address = word counter; imem_write_data = assembled word.
    - Increment the word counter.
    - After word N−1 → CHECK if LOADER_CHECKSUM_EN is defined, else → DONE.
  - DONE: load_done=1 for one cycle, core_hold=0, → IDLE.
  - ERROR: load_error=1 (sticky), core_hold stays 1, → IDLE. Only the next sync byte clears load_error; core_hold is released only by a successful load or by reset.
- Error sources in any non-IDLE state:
  - framing_err.
  - Inter-byte gap > TIMEOUT_CYCLES; the counter clears on every byte_valid.
- Data already written before an error is not rolled back.
- A 0xA5 byte inside a frame is ordinary data, with no resynchronization.
- Word address width is ADDR_BITS; N = 2**ADDR_BITS writes addresses 0..2**ADDR_BITS−1 with no wrap.
- Reset mid-frame: FSM returns to IDLE, core_hold=0, and no further writes occur.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - The sum of all data bytes mod 256 is accumulated in DATA; the accumulator is cleared on sync.
  - CHECK state expects one more byte equal to that sum. Match → DONE; mismatch or timeout → ERROR, with no load_done.
- LOADER_CHECKSUM_EN undefined: no CHECK state, no accumulator; DATA goes straight to DONE.

Decomposition:
- Package uart_imem_loader_pkg:
  - State enum: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
  - SYNC_BYTE = 8'hA5.
  - Function computing CLKS_PER_BIT.
- One sub-module, uart_rx_byte:
  - Synchronizer, bit timing and framing check.
  - Outputs byte_valid, byte_data[7:0], framing_err.
  - Parameter CLKS_PER_BIT.

Test Plan:
- Bench parameters for all scenarios: CLOCK_HZ=1000000, BAUD=100000 (10 clk/bit), ADDR_BITS=4, TIMEOUT_CYCLES=500.
- Normal load: send A5 02 00 78 56 34 12 EF BE AD DE → writes (0, 0x12345678) then (1, 0xDEADBEEF), each enable one cycle; core_hold high from sync until load_done pulse, then low; load_error=0.
- Zero length and preamble garbage: send 00 FF A5 00 00 → no writes, one load_done pulse, core_hold returns to 0.
- Oversize length: send A5 11 00 (N=17 > 16) → no writes, load_error=1, core_hold stays 1; a following good frame clears load_error and pulses load_done.
- Faults mid-frame:
  - Framing error: drive the stop bit low on the 3rd data byte → load_error=1, no further writes.
  - Timeout: after A5 01 00 11, stall 600 cycles → load_error=1.
- Reset mid-frame: assert resetn=0 for one cycle after byte 2 of a word → all outputs 0, FSM in IDLE; a full new frame loads correctly.
- With LOADER_CHECKSUM_EN: A5 01 00 01 02 03 04 0A → load_done; the same frame with checksum 0B → load_error=1, core_hold=1, and word 0x04030201 is still written at address 0.
